pe_dot_sequencer: RTL

Job controller for a single multiply-accumulate PE. It accepts a dot-product job of N operand pairs and clears the PE accumulator. It then streams the activation/weight pairs into the PE, waits out the PE pipeline, captures the sum and presents it on a valid/ready result port. It sits between the operand buffer/DMA and a pe instance, whose accumulator can only be cleared through its reset input.

---
 rtl/pe_dot_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pe_dot_sequencer.sv
// Job controller for one multiply-accumulate PE: clears the PE, streams N operand
// pairs into it, waits out the PE pipeline and returns the sum on a valid/ready port.
module pe_dot_sequencer #(
    parameter int BW         = 8,
    parameter int LEN_W      = 8,
    parameter int PE_LATENCY = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_start_ready,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [BW-1:0]     i_activation,
    input  logic [BW-1:0]     i_weight,
    output logic              o_pe_reset,
    output logic [BW-1:0]     o_pe_activation,
    output logic [BW-1:0]     o_pe_weight,
    input  logic [2*BW-1:0]   i_pe_output,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic [2*BW-1:0]   o_result,
    output logic              o_busy
);

    localparam int DCW = (PE_LATENCY < 1) ? 1 : $clog2(PE_LATENCY + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PE_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        STREAM,
        DRAIN,
        RESULT
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [LEN_W-1:0]  pair_cnt;
    logic [LEN_W-1:0]  pair_cnt_d;
    logic [DCW-1:0]    drain_cnt;
    logic [DCW-1:0]    drain_cnt_d;
    logic              pe_reset_d;
    logic [BW-1:0]     pe_act_d;
    logic [BW-1:0]     pe_wgt_d;
    logic [2*BW-1:0]   result_d;
    logic              result_valid_d;

    // Handshake readiness is a pure state decode, so there is no path from i_op_valid.
    assign o_start_ready = (state == IDLE);
    assign o_op_ready    = (state == STREAM);
    assign o_busy        = (state != IDLE);

    always_comb begin
        state_d        = state;
        pair_cnt_d     = pair_cnt;
        drain_cnt_d    = drain_cnt;
        pe_reset_d     = 1'b0;
        pe_act_d       = '0;
        pe_wgt_d       = '0;
        result_d       = o_result;
        result_valid_d = o_result_valid;

        case (state)
            IDLE: begin
                if (i_start) begin
                    pair_cnt_d = i_length;
                    pe_reset_d = 1'b1;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                drain_cnt_d = '0;
                state_d     = (pair_cnt == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                // Bubbles leave the operand registers at zero so the PE adds nothing.
                if (i_op_valid) begin
                    pe_act_d   = i_activation;
                    pe_wgt_d   = i_weight;
                    pair_cnt_d = pair_cnt - LEN_W'(1);
                    if (pair_cnt == LEN_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    result_d       = i_pe_output;
                    result_valid_d = 1'b1;
                    state_d        = RESULT;
                end else begin
                    drain_cnt_d = drain_cnt + DCW'(1);
                end
            end
            RESULT: begin
                if (i_result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The PE clear is held through our own reset so an aborted job leaves no residue.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            pair_cnt        <= '0;
            drain_cnt       <= '0;
            o_pe_reset      <= 1'b1;
            o_pe_activation <= '0;
            o_pe_weight     <= '0;
            o_result        <= '0;
            o_result_valid  <= 1'b0;
        end else begin
            state           <= state_d;
            pair_cnt        <= pair_cnt_d;
            drain_cnt       <= drain_cnt_d;
            o_pe_reset      <= pe_reset_d;
            o_pe_activation <= pe_act_d;
            o_pe_weight     <= pe_wgt_d;
            o_result        <= result_d;
            o_result_valid  <= result_valid_d;
        end
    end

endmodule
